// File: rtl/adder_vector_driver.sv
// LFSR-driven stimulus/response checker for a two-operand adder with fixed latency.
// Optional macro ADDER_VECTOR_STOP_ON_ERR_EN: end the run on the first mismatch.
module adder_vector_driver #(
  parameter int unsigned BITS    = 8,
  parameter int unsigned LATENCY = 0
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic [15:0]     seed,
  input  logic [15:0]     num_vectors,
  output logic [BITS-1:0] A,
  output logic [BITS-1:0] B,
  input  logic            carry,
  input  logic [BITS-1:0] sum,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [15:0]     err_count,
  output logic [15:0]     vec_count,
  output logic [BITS-1:0] first_err_a,
  output logic [BITS-1:0] first_err_b
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam int unsigned DEPTH      = LATENCY + 1;
  localparam logic [15:0] LFSR_INIT  = 16'hACE1;
  localparam logic [15:0] LFSR_MASK  = 16'hB400;
  localparam logic [3:0]  DRAIN_LAST = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  state_t          state_q, state_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [BITS-1:0] a_q, a_d, b_q, b_d;
  logic [15:0]     vec_q, vec_d, num_q, num_d, err_q, err_d;
  logic [BITS-1:0] fa_q, fa_d, fb_q, fb_d;
  logic [3:0]      drain_q, drain_d;

  // Stage 0 is loaded on the same edge as A/B; stage LATENCY lines up with the DUT result.
  logic            vld_q [DEPTH];
  logic [BITS:0]   exp_q [DEPTH];
  logic [BITS-1:0] opa_q [DEPTH];
  logic [BITS-1:0] opb_q [DEPTH];

  logic [15:0]     lfsr_step;
  logic [BITS-1:0] a_next, b_next;
  logic [BITS:0]   exp_next;
  logic            accept, mismatch, stop_now, issue, flush;

  always_comb begin
    lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : '0);
    a_next    = lfsr_q[BITS-1:0];
    b_next    = lfsr_q[15 -: BITS];
    exp_next  = {1'b0, a_next} + {1'b0, b_next};
    accept    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    mismatch  = vld_q[LATENCY] && !accept && ({carry, sum} != exp_q[LATENCY]);
`ifdef ADDER_VECTOR_STOP_ON_ERR_EN
    stop_now  = mismatch && ((state_q == S_RUN) || (state_q == S_DRAIN));
`else
    stop_now  = 1'b0;
`endif
    issue     = (state_q == S_RUN) && !stop_now;
    flush     = accept || stop_now;

    state_d = state_q;
    lfsr_d  = lfsr_q;
    a_d     = a_q;
    b_d     = b_q;
    vec_d   = vec_q;
    num_d   = num_q;
    err_d   = err_q;
    fa_d    = fa_q;
    fb_d    = fb_q;
    drain_d = drain_q;

    if (mismatch) begin
      if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
      if (err_q == '0) begin
        fa_d = opa_q[LATENCY];
        fb_d = opb_q[LATENCY];
      end
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          lfsr_d  = (seed == '0) ? LFSR_INIT : seed;
          num_d   = num_vectors;
          err_d   = '0;
          vec_d   = '0;
          fa_d    = '0;
          fb_d    = '0;
          state_d = (num_vectors == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (stop_now) begin
          state_d = S_DONE;
        end else begin
          a_d    = a_next;
          b_d    = b_next;
          lfsr_d = lfsr_step;
          vec_d  = vec_q + 16'd1;
          if (vec_q + 16'd1 == num_q) begin
            state_d = (LATENCY == 0) ? S_DONE : S_DRAIN;
            drain_d = '0;
          end
        end
      end
      S_DRAIN: begin
        if (stop_now || (drain_q == DRAIN_LAST)) state_d = S_DONE;
        else                                     drain_d = drain_q + 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      lfsr_q  <= LFSR_INIT;
      a_q     <= '0;
      b_q     <= '0;
      vec_q   <= '0;
      num_q   <= '0;
      err_q   <= '0;
      fa_q    <= '0;
      fb_q    <= '0;
      drain_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        vld_q[i] <= 1'b0;
        exp_q[i] <= '0;
        opa_q[i] <= '0;
        opb_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      vec_q   <= vec_d;
      num_q   <= num_d;
      err_q   <= err_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      drain_q <= drain_d;
      vld_q[0] <= issue;
      exp_q[0] <= exp_next;
      opa_q[0] <= a_next;
      opb_q[0] <= b_next;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        vld_q[i] <= flush ? 1'b0 : vld_q[i-1];
        exp_q[i] <= exp_q[i-1];
        opa_q[i] <= opa_q[i-1];
        opb_q[i] <= opb_q[i-1];
      end
    end
  end

  // The last compare may land in the first DONE cycle, so pass also watches the live result.
  assign pass        = (state_q == S_DONE) && (err_q == '0) && !mismatch;
  assign done        = (state_q == S_DONE);
  assign busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign A           = a_q;
  assign B           = b_q;
  assign err_count   = err_q;
  assign vec_count   = vec_q;
  assign first_err_a = fa_q;
  assign first_err_b = fb_q;

endmodule

// File: tb/tb_adder_vector_driver.sv
// Bench: four driver instances (ideal L=0, ideal L=3, sum[0] stuck L=0, carry stuck L=2).
module tb_adder_vector_driver;

`ifdef ADDER_VECTOR_STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] seed = '0;
  logic [15:0] num = '0;

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  logic [7:0]  A_0, B_0, sum_0, fa_0, fb_0;
  logic        carry_0, busy_0, done_0, pass_0;
  logic [15:0] err_0, vec_0;
  logic [7:0]  A_3, B_3, sum_3, fa_3, fb_3;
  logic        carry_3, busy_3, done_3, pass_3;
  logic [15:0] err_3, vec_3;
  logic [7:0]  A_s, B_s, sum_s, fa_s, fb_s;
  logic        carry_s, busy_s, done_s, pass_s;
  logic [15:0] err_s, vec_s;
  logic [7:0]  A_c, B_c, sum_c, fa_c, fb_c;
  logic        carry_c, busy_c, done_c, pass_c;
  logic [15:0] err_c, vec_c;

  // Adders under test
  assign {carry_0, sum_0} = {1'b0, A_0} + {1'b0, B_0};

  logic [8:0] p3 [3];
  always_ff @(posedge clock) begin
    p3[0] <= {1'b0, A_3} + {1'b0, B_3};
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign {carry_3, sum_3} = p3[2];

  logic [8:0] ts;
  assign ts      = {1'b0, A_s} + {1'b0, B_s};
  assign sum_s   = {ts[7:1], 1'b0};
  assign carry_s = ts[8];

  logic [7:0] pc [2];
  always_ff @(posedge clock) begin
    pc[0] <= A_c + B_c;
    pc[1] <= pc[0];
  end
  assign sum_c   = pc[1];
  assign carry_c = 1'b1;

  adder_vector_driver #(.BITS(8), .LATENCY(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .start(start), .seed(seed), .num_vectors(num),
    .A(A_0), .B(B_0), .carry(carry_0), .sum(sum_0), .busy(busy_0), .done(done_0),
    .pass(pass_0), .err_count(err_0), .vec_count(vec_0), .first_err_a(fa_0), .first_err_b(fb_0));

  adder_vector_driver #(.BITS(8), .LATENCY(3)) dut3 (
    .clock(clock), .reset_n(reset_n), .start(start), .seed(seed), .num_vectors(num),
    .A(A_3), .B(B_3), .carry(carry_3), .sum(sum_3), .busy(busy_3), .done(done_3),
    .pass(pass_3), .err_count(err_3), .vec_count(vec_3), .first_err_a(fa_3), .first_err_b(fb_3));

  adder_vector_driver #(.BITS(8), .LATENCY(0)) duts (
    .clock(clock), .reset_n(reset_n), .start(start), .seed(seed), .num_vectors(num),
    .A(A_s), .B(B_s), .carry(carry_s), .sum(sum_s), .busy(busy_s), .done(done_s),
    .pass(pass_s), .err_count(err_s), .vec_count(vec_s), .first_err_a(fa_s), .first_err_b(fb_s));

  adder_vector_driver #(.BITS(8), .LATENCY(2)) dutc (
    .clock(clock), .reset_n(reset_n), .start(start), .seed(seed), .num_vectors(num),
    .A(A_c), .B(B_c), .carry(carry_c), .sum(sum_c), .busy(busy_c), .done(done_c),
    .pass(pass_c), .err_count(err_c), .vec_count(vec_c), .first_err_a(fa_c), .first_err_b(fb_c));

  typedef struct {
    logic [15:0] seed;
    logic [15:0] num;
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
    int          poke;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference model of the stuck-sum and stuck-carry runs
  task automatic model(input logic [15:0] sd, input logic [15:0] n,
                       output logic [15:0] es, output logic [7:0] as, output logic [7:0] bs,
                       output logic [15:0] ec, output logic [7:0] ac, output logic [7:0] bc,
                       output logic [7:0] last_a, output logic [7:0] last_b);
    logic [15:0] l;
    logic [8:0]  s;
    l = (sd == 16'h0) ? 16'hACE1 : sd;
    es = 0; ec = 0; as = 0; bs = 0; ac = 0; bc = 0; last_a = 0; last_b = 0;
    for (int k = 0; k < int'(n); k++) begin
      s = {1'b0, l[7:0]} + {1'b0, l[15:8]};
      if (s[0]) begin
        if (es == 0) begin as = l[7:0]; bs = l[15:8]; end
        es++;
      end
      if (!s[8]) begin
        if (ec == 0) begin ac = l[7:0]; bc = l[15:8]; end
        ec++;
      end
      last_a = l[7:0];
      last_b = l[15:8];
      l = lfsr_next(l);
    end
    if (STOP) begin
      if (es > 1) es = 1;
      if (ec > 1) ec = 1;
    end
  endtask

  task automatic run(input vec_t v, input bit model_chk);
    int n_busy, d3;
    logic [7:0]  fa, fb, as, bs, ac, bc, la, lb;
    logic [15:0] es, ec;
    model(v.seed, v.num, es, as, bs, ec, ac, bc, la, lb);
    @(negedge clock);
    seed = v.seed; num = v.num; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n_busy = 0; fa = '0; fb = '0;
    while (busy_0 && n_busy < 1000) begin
      n_busy++;
      if (v.poke != 0 && n_busy == v.poke) begin
        start = 1'b1; seed = 16'h5A5A; num = 16'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
      if (n_busy == 1) begin fa = A_0; fb = B_0; end
    end
    start = 1'b0;
    chk("busy_cycles", n_busy, 32'(v.num));
    chk("first_a", fa, v.exp_a);
    chk("first_b", fb, v.exp_b);
    d3 = 0;
    while (!done_3 && d3 < 20) begin
      d3++;
      @(negedge clock);
    end
    chk("l3_drain_cycles", d3, 3);
    @(negedge clock);
    chk("l0_done", done_0, 1'b1);
    chk("l0_pass", pass_0, 1'b1);
    chk("l0_err", err_0, 0);
    chk("l0_vec", vec_0, 32'(v.num));
    chk("l0_a_hold", A_0, la);
    chk("l0_b_hold", B_0, lb);
    chk("l3_pass", pass_3, 1'b1);
    chk("l3_err", err_3, 0);
    chk("l3_vec", vec_3, 32'(v.num));
    if (model_chk) begin
      chk("stuck_sum_err", err_s, es);
      chk("stuck_sum_pass", pass_s, (es == 0));
      chk("stuck_sum_first_a", fa_s, as);
      chk("stuck_sum_first_b", fb_s, bs);
      chk("stuck_carry_err", err_c, ec);
      chk("stuck_carry_pass", pass_c, (ec == 0));
      chk("stuck_carry_first_a", fa_c, ac);
      chk("stuck_carry_first_b", fb_c, bc);
      chk("stuck_carry_done", done_c, 1'b1);
    end
  endtask

  initial begin
    tbl[0] = '{16'h1234, 16'd100, 8'h34, 8'h12, 0};
    tbl[1] = '{16'h0000, 16'd5,   8'hE1, 8'hAC, 0};
    tbl[2] = '{16'hFFFF, 16'd1,   8'hFF, 8'hFF, 0};
    tbl[3] = '{16'h00A5, 16'd200, 8'hA5, 8'h00, 0};
    tbl[4] = '{16'h1234, 16'd100, 8'h34, 8'h12, 10};

    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_busy", busy_0, 1'b0);
    chk("rst_done", done_0, 1'b0);
    chk("rst_pass", pass_0, 1'b0);
    chk("rst_a", A_3, 0);
    chk("rst_err", err_3, 0);
    reset_n = 1'b1;
    @(negedge clock);

    // Zero-length run: DONE next cycle, operands untouched
    seed = 16'h1234; num = 16'd0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("zero_done", done_0, 1'b1);
    chk("zero_busy", busy_0, 1'b0);
    chk("zero_pass", pass_0, 1'b1);
    chk("zero_vec", vec_0, 0);
    chk("zero_a", A_0, 0);
    chk("zero_b", B_0, 0);
    @(negedge clock);
    chk("zero_stuck_sum_pass", pass_s, 1'b1);
    chk("zero_stuck_carry_pass", pass_c, 1'b1);

    for (int i = 0; i < 5; i++) run(tbl[i], (tbl[i].poke == 0) || !STOP);

    // Reset asserted mid-run, then a clean run after release
    @(negedge clock);
    seed = 16'h1234; num = 16'd100; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (19) @(negedge clock);
    chk("mid_busy_before", busy_0, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy_0, 1'b0);
    chk("mid_rst_done", done_0, 1'b0);
    chk("mid_rst_vec", vec_0, 0);
    chk("mid_rst_a", A_0, 0);
    chk("mid_rst_b", B_0, 0);
    chk("mid_rst_err_s", err_s, 0);
    chk("mid_rst_first_a_s", fa_s, 0);
    chk("mid_rst_first_b_s", fb_s, 0);
    @(negedge clock);
    reset_n = 1'b1;
    run(tbl[0], 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_vector_driver.md
Name: adder_vector_driver

Overview:
- Stimulus and response end of the two-operand adder interface: drives A/B into an adder under test and consumes its carry/sum.
- Generates pseudo-random operand pairs from an LFSR and presents one pair per clock.
- Compares the returned {carry,sum} against A+B after a fixed DUT latency and accumulates pass/fail status.
- Sits beside any adder with the clock/A/B/carry/sum port set; used in built-in self-test and in bring-up benches.

Parameters:
- BITS, 8, operand and sum width; legal range 1..16.
- LATENCY, 0, DUT cycles from A/B presented to carry/sum valid; 0 means combinational DUT; legal range 0..15.

Ports:
- clock  input  1  sole clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a run when idle.
- seed  input  16  LFSR seed, sampled on accepted start.
- num_vectors  input  16  vectors to issue, sampled on accepted start.
- A  output  BITS  operand A to DUT, registered.
- B  output  BITS  operand B to DUT, registered.
- carry  input  1  DUT carry-out.
- sum  input  BITS  DUT sum.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  high in DONE, held until next accepted start.
- pass  output  1  valid when done; 1 means err_count == 0.
- err_count  output  16  mismatches seen; saturates at 16'hFFFF.
- vec_count  output  16  vectors issued this run.
- first_err_a  output  BITS  A of first mismatching vector.
- first_err_b  output  BITS  B of first mismatching vector.

Behaviour:
- Reset (async assert, sync release): state IDLE; A, B, busy, done, pass, err_count, vec_count, first_err_* all 0; LFSR 16'hACE1; compare pipeline cleared.
- LFSR: 16-bit Galois, mask 16'hB400, shifts right. A = lfsr[BITS-1:0], B = lfsr[15 -: BITS]. A seed of 0 is replaced by 16'hACE1.
- IDLE/DONE with start=1:
  - Load LFSR from seed; clear err_count, vec_count, first_err_*, done, pass.
  - If num_vectors == 0, go to DONE with pass=1 next cycle; otherwise go to RUN.
- RUN, every cycle:
  - Register A/B from the current LFSR value, step the LFSR, increment vec_count.
  - Push expected {1'b0,A}+{1'b0,B} (BITS+1 bits) and a valid bit into a LATENCY-deep shift pipe.
  - Leave RUN after the cycle vec_count reaches num_vectors.
  - A/B hold their last value after RUN.
- Compare:
  - The pipe output is aligned with the cycle in which the DUT returns the result for that vector.
  - LATENCY=0: compare in the same cycle A/B are driven.
  - When the pipe output is valid and {carry,sum} differs from expected, increment err_count (saturating).
  - On the first mismatch only, capture that vector's A/B into first_err_a/first_err_b. Operand copies travel in the pipe.
- DRAIN: wait until the compare pipe is empty (exactly LATENCY cycles), then go to DONE. With LATENCY=0, go from RUN directly to DONE.
- DONE: done=1, pass=(err_count==0); both hold until the next accepted start.
- start while busy is ignored; no state change.
- reset_n asserted mid-run: immediate return to reset values; any partial result is discarded.
- carry/sum are ignored whenever no valid compare is pending.

Optional Feature:
- Macro: ADDER_VECTOR_STOP_ON_ERR_EN.
- Defined: on the first mismatch, go directly to DONE next cycle with pass=0.
  - Stop issuing vectors; A/B freeze.
  - Flush in-flight compares without counting them; err_count = 1.
- Undefined: the run always completes all num_vectors; mismatches are only counted.

Test Plan:
- LATENCY=0, ideal combinational adder, seed=16'h1234, num_vectors=100:
  - busy for 100 cycles, then done=1, pass=1, err_count=0, vec_count=100.
  - First A = 16'h1234[7:0] = 8'h34.
- LATENCY=3, ideal 3-stage adder, num_vectors=50: done asserts 3 cycles after the last vector; pass=1, err_count=0.
- LATENCY=0, DUT sum[0] stuck at 0, num_vectors=200:
  - err_count equals the number of vectors with odd A+B.
  - first_err_a/first_err_b equal the first vector with an odd sum; pass=0.
- num_vectors=0 with start: DONE next cycle, pass=1, vec_count=0, A/B remain 0.
- start pulsed again during RUN at cycle 10 of 100: ignored; vec_count ends at 100.
- reset_n low at cycle 20 of a run:
  - all outputs 0 immediately, state IDLE.
  - A new start after release completes normally.
- ADDER_VECTOR_STOP_ON_ERR_EN defined, carry stuck at 1, LATENCY=2:
  - done within 3 cycles of the first mismatch; err_count=1, pass=0, A/B frozen.
